// File: rtl/ram_arbiter.sv
// ram_arbiter
//
// Purpose: shares a single-port synchronous SRAM between three masters:
// the flash loader (image copy at boot), the CPU bus and the diagnostics
// SPI slave. A small FSM (LOAD / RUN / HALTED) selects which masters may
// be granted. Every access is registered: a request sampled in cycle N
// drives the SRAM port and the winner's grant pulse in cycle N+1. A read
// is returned with rd_valid/rd_owner in cycle N+2.
//
// Optional feature: define DIAG_AGE_EN to enable diag request aging in
// RUN. A pending diag request that has waited AGE_LIMIT cycles then wins
// over the CPU once. Without the macro the CPU has strict priority and no
// counter exists.
//
// Ports:
//   clk, rst                  clock (rising edge), synchronous active-high reset
//   ld_req/we/addr/wdata      flash-loader access
//   ld_done                   image load complete (sticky until rst)
//   cpu_req/we/addr/wdata     CPU bus access
//   diag_req/we/addr/wdata    diagnostics access
//   halt                      diagnostics halt request
//   ram_rdata                 SRAM read data, valid the cycle after a read
//   ram_addr/wdata/cs/we      registered SRAM port
//   ld_gnt/cpu_gnt/diag_gnt   one-cycle grant pulses, coincident with ram_cs
//   rd_valid/rd_owner/rd_data read return (owner 0 ld, 1 cpu, 2 diag)
//   cpu_rdy                   CPU ready, high only in RUN with halt low
//   state                     FSM state for LED/debug (LOAD=0 RUN=1 HALTED=2)

module ram_arbiter #(
  parameter int unsigned AGE_LIMIT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ld_req,
  input  logic        ld_we,
  input  logic [15:0] ld_addr,
  input  logic [7:0]  ld_wdata,
  input  logic        ld_done,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  input  logic        diag_req,
  input  logic        diag_we,
  input  logic [15:0] diag_addr,
  input  logic [7:0]  diag_wdata,
  input  logic        halt,
  input  logic [7:0]  ram_rdata,
  output logic [15:0] ram_addr,
  output logic [7:0]  ram_wdata,
  output logic        ram_cs,
  output logic        ram_we,
  output logic        ld_gnt,
  output logic        cpu_gnt,
  output logic        diag_gnt,
  output logic        rd_valid,
  output logic [1:0]  rd_owner,
  output logic [7:0]  rd_data,
  output logic        cpu_rdy,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    RUN     = 2'd1,
    HALTED  = 2'd2,
    ILLEGAL = 2'd3
  } state_t;

  state_t      cur_state, next_state;
  logic        grant_ld, grant_cpu, grant_diag, any_grant;
  logic        age_force;
  logic        sel_we;
  logic [15:0] sel_addr;
  logic [7:0]  sel_wdata;
  logic [1:0]  sel_owner;
  logic [1:0]  gnt_owner;

`ifdef DIAG_AGE_EN
  localparam logic [3:0] AGE_MAX = 4'(AGE_LIMIT);
  logic [3:0] age_cnt;

  // Counts RUN cycles a diag request has been refused; saturates at 15.
  always_ff @(posedge clk) begin
    if (rst) begin
      age_cnt <= 4'd0;
    end else if (cur_state != RUN || !diag_req || grant_diag) begin
      age_cnt <= 4'd0;
    end else if (age_cnt != 4'hF) begin
      age_cnt <= age_cnt + 4'd1;
    end
  end

  assign age_force = (age_cnt == AGE_MAX);
`else
  logic unused_age_limit;
  assign unused_age_limit = (AGE_LIMIT > 32'd15);
  assign age_force        = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_state <= LOAD;
    end else begin
      cur_state <= next_state;
    end
  end

  // Next state and grant decision for the requests sampled this cycle.
  // The cycle that leaves LOAD issues no grant; a halt sampled in RUN
  // still lets that cycle's CPU request through.
  always_comb begin
    next_state = cur_state;
    grant_ld   = 1'b0;
    grant_cpu  = 1'b0;
    grant_diag = 1'b0;
    case (cur_state)
      LOAD: begin
        if (ld_done) begin
          next_state = RUN;
        end else begin
          grant_ld = ld_req;
        end
      end
      RUN: begin
        if (halt) begin
          next_state = HALTED;
        end
        if (diag_req && age_force) begin
          grant_diag = 1'b1;
        end else if (cpu_req) begin
          grant_cpu = 1'b1;
        end else if (diag_req) begin
          grant_diag = 1'b1;
        end
      end
      HALTED: begin
        if (!halt) begin
          next_state = RUN;
        end
        grant_diag = diag_req;
      end
      default: begin
        next_state = LOAD;
      end
    endcase
  end

  assign any_grant = grant_ld | grant_cpu | grant_diag;

  always_comb begin
    sel_we    = ld_we;
    sel_addr  = ld_addr;
    sel_wdata = ld_wdata;
    sel_owner = 2'd0;
    if (grant_cpu) begin
      sel_we    = cpu_we;
      sel_addr  = cpu_addr;
      sel_wdata = cpu_wdata;
      sel_owner = 2'd1;
    end else if (grant_diag) begin
      sel_we    = diag_we;
      sel_addr  = diag_addr;
      sel_wdata = diag_wdata;
      sel_owner = 2'd2;
    end
  end

  // Registered SRAM port. Address and write data hold their last value
  // on idle cycles so the SRAM pins do not toggle needlessly.
  always_ff @(posedge clk) begin
    if (rst) begin
      ram_cs    <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= 16'h0000;
      ram_wdata <= 8'h00;
      ld_gnt    <= 1'b0;
      cpu_gnt   <= 1'b0;
      diag_gnt  <= 1'b0;
      gnt_owner <= 2'd0;
    end else begin
      ram_cs   <= any_grant;
      ram_we   <= any_grant & sel_we;
      ld_gnt   <= grant_ld;
      cpu_gnt  <= grant_cpu;
      diag_gnt <= grant_diag;
      if (any_grant) begin
        ram_addr  <= sel_addr;
        ram_wdata <= sel_wdata;
        gnt_owner <= sel_owner;
      end
    end
  end

  // Read return tracks the access on the SRAM port one cycle earlier;
  // reset cancels any read still in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_owner <= 2'd0;
    end else begin
      rd_valid <= ram_cs & ~ram_we;
      if (ram_cs && !ram_we) begin
        rd_owner <= gnt_owner;
      end
    end
  end

  // The SRAM presents its data in the return cycle, so it is passed
  // straight through and forced to zero otherwise.
  assign rd_data = rd_valid ? ram_rdata : 8'h00;
  assign cpu_rdy = !rst && (cur_state == RUN) && !halt;
  assign state   = cur_state;

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter AGE_LIMIT, default 15: max cycles a pending diag request waits in RUN (used only with DIAG_AGE_EN).
REQ-002 clk  in  1  internal HFOSC fabric clock; all state on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 ld_req, ld_we  in  1 each  flash-loader access request / write strobe.
REQ-005 ld_addr  in  16  flash-loader RAM address; ld_wdata  in  8  loader write data.
REQ-006 ld_done  in  1  image load complete (read_complete); once high stays high until rst.
REQ-007 cpu_req, cpu_we  in  1 each  CPU bus access request (decoded cs) / write strobe.
REQ-008 cpu_addr  in  16; cpu_wdata  in  8  CPU bus address and data.
REQ-009 diag_req, diag_we  in  1 each; diag_addr  in  16; diag_wdata  in  8  diagnostics SPI-slave port.
REQ-010 halt  in  1  diagnostics halt request.
REQ-011 ram_rdata  in  8  sram64k synchronous read data.
REQ-012 ram_addr  out  16; ram_wdata  out  8; ram_cs, ram_we  out  1 each  registered SRAM port.
REQ-013 ld_gnt, cpu_gnt, diag_gnt  out  1 each  one-cycle grant pulse, coincident with ram_cs.
REQ-014 rd_valid  out  1; rd_owner  out  2 (0 ld, 1 cpu, 2 diag); rd_data  out  8  read return.
REQ-015 cpu_rdy  out  1  CPU RDY: high only in RUN with halt low.
REQ-016 state  out  2  LOAD=0, RUN=1, HALTED=2, for LED/debug.

Function
REQ-017 FSM states LOAD, RUN, HALTED; encoding 3 illegal, recovers to LOAD next cycle.
REQ-018 LOAD: only ld_req granted; cpu_req, diag_req ignored (dropped, not queued).
REQ-019 LOAD->RUN on first cycle ld_done sampled high; no grant issued that cycle.
REQ-020 RUN: cpu_req wins over diag_req; diag granted only in cycles without cpu_req.
REQ-021 RUN->HALTED when halt sampled high; cpu_rdy drops combinationally same cycle; a cpu_req sampled that cycle is still granted (one-cycle drain).
REQ-022 HALTED: only diag_req granted; HALTED->RUN when halt sampled low; cpu_rdy rises the cycle after.
REQ-023 Request sampled cycle N -> ram_cs/ram_we/ram_addr/ram_wdata and winner's gnt driven in cycle N+1 for exactly one cycle.
REQ-024 Read (we=0) granted in N+1 -> rd_valid=1, rd_owner=winner, rd_data=ram_rdata in N+2; writes never produce rd_valid.
REQ-025 Back-to-back requests sustain one access per cycle; no idle cycle between grants.
REQ-026 Idle cycles: ram_cs=0, ram_we=0, ram_addr/ram_wdata hold last value.
REQ-027 ram_we asserted only with ram_cs.
REQ-028 ld_done deasserting outside rst is ignored; FSM never returns to LOAD except via rst or illegal state.

Reset
REQ-029 rst high at a clock edge: state=LOAD, all gnt=0, ram_cs=0, ram_we=0, ram_addr=0, ram_wdata=0, rd_valid=0, rd_owner=0, rd_data=0, age counter=0, cpu_rdy=0.
REQ-030 rst mid-access: a pending rd_valid is cancelled; no grant in the reset cycle or the cycle after.

Configuration
REQ-031 Macro DIAG_AGE_EN defined: in RUN, a 4-bit saturating age counter increments each cycle diag_req is high and not granted; when count equals AGE_LIMIT, the next grant goes to diag even if cpu_req is high (cpu waits one cycle); counter clears on diag grant or diag_req low.
REQ-032 DIAG_AGE_EN undefined: strict cpu priority in RUN; no counter logic synthesized.

Verification
REQ-033 rst, ld_req=1 ld_we=1 ld_addr=0x1234 ld_wdata=0xA5, cpu_req=1 -> next cycle ld_gnt=1, ram_addr=0x1234, ram_we=1, cpu_gnt=0.
REQ-034 ld_done=1, then cpu_req=1 read addr=0xFFFC with ram_rdata=0x00 at 0xFFFC -> cpu_gnt at N+1, rd_valid=1 rd_owner=1 rd_data=0x00 at N+2.
REQ-035 RUN, cpu_req and diag_req both high 20 cycles -> without DIAG_AGE_EN diag_gnt never asserts; with DIAG_AGE_EN and AGE_LIMIT=15 exactly one diag_gnt by cycle 17.
REQ-036 halt=1 while cpu_req=1 -> cpu_rdy=0 same cycle, one final cpu_gnt, then state=HALTED; diag read 0x8000 returns rd_owner=2.
REQ-037 rst asserted the cycle after a granted read -> rd_valid stays 0, state=LOAD, cpu_rdy=0.
REQ-038 halt=0 from HALTED -> state=RUN next cycle, cpu_rdy=1 the cycle after.
